spi_frame_receiver: RTL and testbench

Parametrised multi-channel SPI slave receiver for the audio front end. It replaces the fixed 12-bit single-word receiver. A single chip-select-low frame carries NUM_CHANNELS fixed-length slots. From each slot it skips a configurable number of leading bits and captures a DATA_WIDTH word, either MSB-first or LSB-first. Captured channels are presented on a packed bus with per-channel strobes, a frame-complete strobe and a frame-abort strobe. The block feeds the downstream sample buffer/filter chain directly.

---
 rtl/spi_frame_receiver.sv | 119 +++++++++++
 tb/tb_spi_frame_receiver.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// Multi-channel SPI slave frame receiver: splits one chip-select-low frame into
// NUM_CHANNELS slots and captures a DATA_WIDTH word from each slot.
module spi_frame_receiver #(
  parameter int DATA_WIDTH   = 12,
  parameter int SLOT_BITS    = 16,
  parameter int LEAD_BITS    = 4,
  parameter int NUM_CHANNELS = 2,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                               s_clk,
  input  logic                               reset,
  input  logic                               cs,
  input  logic                               mosi,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CHANNELS-1:0]            ch_valid,
  output logic                               frame_valid,
  output logic                               frame_abort,
  output logic                               busy
);

  localparam int BW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int SW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [BW-1:0] LAST_BIT  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(LEAD_BITS + DATA_WIDTH - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                r_state;
  logic [BW-1:0]         r_bit_cnt;
  logic [SW-1:0]         r_slot_cnt;
  logic [DATA_WIDTH-1:0] r_shift;

  logic                  w_in_data;
  logic                  w_last_data;
  logic                  w_last_bit;
  logic                  w_last_slot;
  logic [DATA_WIDTH-1:0] w_next_shift;

  // The word including the bit sampled this edge, so capture can load it directly.
  always_comb begin
    w_in_data   = (int'(r_bit_cnt) >= LEAD_BITS) &&
                  (int'(r_bit_cnt) <  LEAD_BITS + DATA_WIDTH);
    w_last_data = (r_bit_cnt == LAST_DATA);
    w_last_bit  = (r_bit_cnt == LAST_BIT);
    w_last_slot = (r_slot_cnt == LAST_SLOT);
    if (MSB_FIRST)
      w_next_shift = (r_shift << 1) | DATA_WIDTH'(mosi);
    else
      w_next_shift = (r_shift >> 1) | (DATA_WIDTH'(mosi) << (DATA_WIDTH - 1));
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, matching the flops it becomes.
  always_ff @(posedge s_clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_slot_cnt  <= '0;
      r_shift     <= '0;
      data_out    <= '0;
      ch_valid    <= '0;
      frame_valid <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ch_valid    <= '0;
      frame_valid <= 1'b0;
      frame_abort <= 1'b0;
      case (r_state)
        IDLE, SHIFT: begin
          if (cs) begin
            frame_abort <= (r_state == SHIFT);
            r_state     <= IDLE;
            busy        <= 1'b0;
            r_bit_cnt   <= '0;
            r_slot_cnt  <= '0;
            r_shift     <= '0;
          end else begin
            r_state <= SHIFT;
            busy    <= 1'b1;
            if (w_in_data)
              r_shift <= w_next_shift;
            if (w_last_bit) begin
              r_bit_cnt  <= '0;
              r_slot_cnt <= r_slot_cnt + 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_last_data) begin
              for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (r_slot_cnt == SW'(k)) begin
                  data_out[k*DATA_WIDTH +: DATA_WIDTH] <= w_next_shift;
                  ch_valid[k]                          <= 1'b1;
                end
              end
              // Last channel captured: stop counting and ignore the rest of the frame.
              if (w_last_slot) begin
                r_state     <= DONE;
                busy        <= 1'b0;
                frame_valid <= 1'b1;
                r_bit_cnt   <= '0;
                r_slot_cnt  <= '0;
                r_shift     <= '0;
              end
            end
          end
        end
        DONE: begin
          if (cs)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: MSB-first, LSB-first and
// single-channel instances checked against a bit-stream reference model.
module tb_spi_frame_receiver;

  logic clk = 1'b0;
  logic rst, cs, mosi, cs1, mosi1;

  logic [23:0] d_msb, d_lsb;
  logic [1:0]  v_msb, v_lsb;
  logic        fv_msb, fa_msb, b_msb, fv_lsb, fa_lsb, b_lsb;
  logic [11:0] d_one;
  logic [0:0]  v_one;
  logic        fv_one, fa_one, b_one;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  spi_frame_receiver dut (
    .s_clk(clk), .reset(rst), .cs(cs), .mosi(mosi),
    .data_out(d_msb), .ch_valid(v_msb), .frame_valid(fv_msb),
    .frame_abort(fa_msb), .busy(b_msb)
  );

  spi_frame_receiver #(.MSB_FIRST(1'b0)) dut_lsb (
    .s_clk(clk), .reset(rst), .cs(cs), .mosi(mosi),
    .data_out(d_lsb), .ch_valid(v_lsb), .frame_valid(fv_lsb),
    .frame_abort(fa_lsb), .busy(b_lsb)
  );

  spi_frame_receiver #(
    .DATA_WIDTH(12), .SLOT_BITS(12), .LEAD_BITS(0), .NUM_CHANNELS(1), .MSB_FIRST(1'b1)
  ) dut_one (
    .s_clk(clk), .reset(rst), .cs(cs1), .mosi(mosi1),
    .data_out(d_one), .ch_valid(v_one), .frame_valid(fv_one),
    .frame_abort(fa_one), .busy(b_one)
  );

  // Reference model for the default two-channel configuration: the frame is
  // kept as the list of bits received since cs fell; words are cut out of it.
  bit          mq[$];
  bit          m_active, m_done;
  logic [11:0] m_msb[2];
  logic [11:0] m_lsb[2];
  logic [1:0]  e_chv;
  logic        e_fv, e_fa, e_busy;

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_msb[0] = '0; m_msb[1] = '0;
    m_lsb[0] = '0; m_lsb[1] = '0;
    e_chv = '0; e_fv = 1'b0; e_fa = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_main(input bit c, input bit d);
    int e, slot, pos;
    logic [11:0] wm, wl;
    e_chv = '0; e_fv = 1'b0; e_fa = 1'b0;
    if (c) begin
      if (m_active && !m_done) e_fa = 1'b1;
      m_active = 1'b0;
      m_done   = 1'b0;
      mq.delete();
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_done   = 1'b0;
        mq.delete();
      end
      mq.push_back(d);
      if (!m_done) begin
        e    = mq.size() - 1;
        slot = e / 16;
        pos  = e % 16;
        if (pos == 15) begin
          for (int i = 0; i < 12; i++) begin
            wm[11-i] = mq[slot*16 + 4 + i];
            wl[i]    = mq[slot*16 + 4 + i];
          end
          m_msb[slot] = wm;
          m_lsb[slot] = wl;
          e_chv[slot] = 1'b1;
          if (slot == 1) begin
            e_fv   = 1'b1;
            m_done = 1'b1;
          end
        end
      end
    end
    e_busy = m_active && !m_done;
  endtask

  // One serial clock: drive on the falling edge, settle past the rising edge.
  task automatic step(input bit ca, input bit da, input bit cb, input bit db);
    @(negedge clk);
    cs = ca; mosi = da; cs1 = cb; mosi1 = db;
    @(posedge clk);
    #1;
    model_main(ca, da);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; mosi = 1'b0; cs1 = 1'b1; mosi1 = 1'b0;
    #2;
    model_reset();
    tests_run++;
    if ({d_msb, v_msb, fv_msb, fa_msb, b_msb} !== 29'd0) begin
      tests_failed++;
      $display("FAIL reset_msb: got %h expected 0", {d_msb, v_msb, fv_msb, fa_msb, b_msb});
    end
    tests_run++;
    if ({d_lsb, v_lsb, fv_lsb, fa_lsb, b_lsb} !== 29'd0) begin
      tests_failed++;
      $display("FAIL reset_lsb: got %h expected 0", {d_lsb, v_lsb, fv_lsb, fa_lsb, b_lsb});
    end
    tests_run++;
    if ({d_one, v_one, fv_one, fa_one, b_one} !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_one: got %h expected 0", {d_one, v_one, fv_one, fa_one, b_one});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed_frame();
    logic [31:0] pat;
    pat = {4'h0, 12'hA5C, 4'hF, 12'h3F1};
    for (int i = 0; i < 32; i++) begin
      step(1'b0, pat[31-i], 1'b1, 1'b0);
      tests_run++;
      if ({v_msb, fv_msb, fa_msb, b_msb} !== {e_chv, e_fv, e_fa, e_busy}) begin
        tests_failed++;
        $display("FAIL dir_strobes edge %0d: got %b expected %b", i,
                 {v_msb, fv_msb, fa_msb, b_msb}, {e_chv, e_fv, e_fa, e_busy});
      end
      if (i == 15) begin
        tests_run++;
        if ({d_msb[11:0], v_msb, fv_msb} !== {12'hA5C, 2'b01, 1'b0}) begin
          tests_failed++;
          $display("FAIL dir_ch0_msb: got %h/%b/%b expected a5c/01/0", d_msb[11:0], v_msb, fv_msb);
        end
        tests_run++;
        if (d_lsb[11:0] !== 12'h3A5) begin
          tests_failed++;
          $display("FAIL dir_ch0_lsb: got %h expected 3a5", d_lsb[11:0]);
        end
      end
      if (i == 31) begin
        tests_run++;
        if ({d_msb, v_msb, fv_msb, b_msb} !== {12'h3F1, 12'hA5C, 2'b10, 1'b1, 1'b0}) begin
          tests_failed++;
          $display("FAIL dir_ch1_msb: got %h/%b/%b/%b expected 3f1a5c/10/1/0",
                   d_msb, v_msb, fv_msb, b_msb);
        end
        tests_run++;
        if ({d_lsb, fv_lsb} !== {12'h8FC, 12'h3A5, 1'b1}) begin
          tests_failed++;
          $display("FAIL dir_ch1_lsb: got %h/%b expected 8fc3a5/1", d_lsb, fv_lsb);
        end
      end
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom), 1'b1, 1'b0);
      if (i == 15) begin
        tests_run++;
        if ({d_msb[11:0], v_msb} !== {m_msb[0], 2'b01}) begin
          tests_failed++;
          $display("FAIL abort_ch0: got %h/%b expected %h/01", d_msb[11:0], v_msb, m_msb[0]);
        end
      end
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if ({fa_msb, fv_msb, b_msb, v_msb} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL abort_pulse: got fa=%b fv=%b busy=%b chv=%b expected 1/0/0/00",
               fa_msb, fv_msb, b_msb, v_msb);
    end
    tests_run++;
    if ({d_msb[23:12], d_lsb[23:12]} !== {12'h3F1, 12'h8FC}) begin
      tests_failed++;
      $display("FAIL abort_ch1_kept: got %h/%h expected 3f1/8fc", d_msb[23:12], d_lsb[23:12]);
    end
    tests_run++;
    if ({d_msb[11:0], d_lsb[11:0]} !== {m_msb[0], m_lsb[0]}) begin
      tests_failed++;
      $display("FAIL abort_ch0_kept: got %h/%h expected %h/%h",
               d_msb[11:0], d_lsb[11:0], m_msb[0], m_lsb[0]);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (fa_msb !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_one_cycle: got %b expected 0", fa_msb);
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'($urandom), 1'b1, 1'b0);
      tests_run++;
      if ({v_msb, fv_msb, fa_msb, b_msb} !== {e_chv, e_fv, e_fa, e_busy}) begin
        tests_failed++;
        $display("FAIL rearm_strobes edge %0d: got %b expected %b", i,
                 {v_msb, fv_msb, fa_msb, b_msb}, {e_chv, e_fv, e_fa, e_busy});
      end
    end
    tests_run++;
    if ({d_msb, d_lsb} !== {m_msb[1], m_msb[0], m_lsb[1], m_lsb[0]}) begin
      tests_failed++;
      $display("FAIL rearm_data: got %h/%h expected %h%h/%h%h",
               d_msb, d_lsb, m_msb[1], m_msb[0], m_lsb[1], m_lsb[0]);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overlong();
    int n_fv;
    n_fv = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'($urandom), 1'b1, 1'b0);
      if (fv_msb === 1'b1) n_fv++;
      tests_run++;
      if (fv_msb !== (i == 31)) begin
        tests_failed++;
        $display("FAIL long_fv edge %0d: got %b expected %b", i, fv_msb, (i == 31));
      end
      tests_run++;
      if (b_msb !== (i < 31)) begin
        tests_failed++;
        $display("FAIL long_busy edge %0d: got %b expected %b", i, b_msb, (i < 31));
      end
      if (i >= 32) begin
        tests_run++;
        if ({v_msb, fa_msb, d_msb} !== {2'b00, 1'b0, m_msb[1], m_msb[0]}) begin
          tests_failed++;
          $display("FAIL long_ignored edge %0d: got %b/%b/%h expected 00/0/%h%h",
                   i, v_msb, fa_msb, d_msb, m_msb[1], m_msb[0]);
        end
      end
    end
    tests_run++;
    if (n_fv != 1) begin
      tests_failed++;
      $display("FAIL long_fv_count: got %0d expected 1", n_fv);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (fa_msb !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_no_abort: got %b expected 0", fa_msb);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 11; i++) step(1'b0, 1'($urandom), 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if ({d_msb, v_msb, fv_msb, fa_msb, b_msb, d_lsb} !== 53'd0) begin
      tests_failed++;
      $display("FAIL midreset_zero: got %h expected 0", {d_msb, v_msb, fv_msb, fa_msb, b_msb, d_lsb});
    end
    @(negedge clk);
    cs  = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'($urandom), 1'b1, 1'b0);
      tests_run++;
      if ({v_msb, fv_msb, fa_msb, b_msb} !== {e_chv, e_fv, e_fa, e_busy}) begin
        tests_failed++;
        $display("FAIL midreset_strobes edge %0d: got %b expected %b", i,
                 {v_msb, fv_msb, fa_msb, b_msb}, {e_chv, e_fv, e_fa, e_busy});
      end
    end
    tests_run++;
    if ({d_msb, d_lsb} !== {m_msb[1], m_msb[0], m_lsb[1], m_lsb[0]}) begin
      tests_failed++;
      $display("FAIL midreset_data: got %h/%h expected %h%h/%h%h",
               d_msb, d_lsb, m_msb[1], m_msb[0], m_lsb[1], m_lsb[0]);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int len, gap;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(45, 1);
      gap = $urandom_range(3, 1);
      for (int i = 0; i < len + gap; i++) begin
        step((i >= len), 1'($urandom), 1'b1, 1'b0);
        tests_run++;
        if ({v_msb, fv_msb, fa_msb, b_msb} !== {e_chv, e_fv, e_fa, e_busy}) begin
          tests_failed++;
          $display("FAIL rnd_strobes_msb f%0d e%0d: got %b expected %b", f, i,
                   {v_msb, fv_msb, fa_msb, b_msb}, {e_chv, e_fv, e_fa, e_busy});
        end
        tests_run++;
        if ({v_lsb, fv_lsb, fa_lsb, b_lsb} !== {e_chv, e_fv, e_fa, e_busy}) begin
          tests_failed++;
          $display("FAIL rnd_strobes_lsb f%0d e%0d: got %b expected %b", f, i,
                   {v_lsb, fv_lsb, fa_lsb, b_lsb}, {e_chv, e_fv, e_fa, e_busy});
        end
        tests_run++;
        if (d_msb !== {m_msb[1], m_msb[0]}) begin
          tests_failed++;
          $display("FAIL rnd_data_msb f%0d e%0d: got %h expected %h%h", f, i, d_msb, m_msb[1], m_msb[0]);
        end
        tests_run++;
        if (d_lsb !== {m_lsb[1], m_lsb[0]}) begin
          tests_failed++;
          $display("FAIL rnd_data_lsb f%0d e%0d: got %h expected %h%h", f, i, d_lsb, m_lsb[1], m_lsb[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] wa, wb;
    logic        hit, exp_busy;
    wa = 12'($urandom);
    wb = 12'($urandom);
    for (int g = 0; g < 25; g++) begin
      if (g < 12)       step(1'b1, 1'b0, 1'b0, wa[11-g]);
      else if (g == 12) step(1'b1, 1'b0, 1'b1, 1'b0);
      else              step(1'b1, 1'b0, 1'b0, wb[11-(g-13)]);
      hit      = (g == 11) || (g == 24);
      exp_busy = (g < 11) || ((g > 12) && (g < 24));
      tests_run++;
      if ({fv_one, v_one, fa_one, b_one} !== {hit, hit, 1'b0, exp_busy}) begin
        tests_failed++;
        $display("FAIL b2b_strobes edge %0d: got %b expected %b", g,
                 {fv_one, v_one, fa_one, b_one}, {hit, hit, 1'b0, exp_busy});
      end
      if (g == 11) begin
        tests_run++;
        if (d_one !== wa) begin
          tests_failed++;
          $display("FAIL b2b_word_a: got %h expected %h", d_one, wa);
        end
      end
      if (g == 24) begin
        tests_run++;
        if (d_one !== wb) begin
          tests_failed++;
          $display("FAIL b2b_word_b: got %h expected %h", d_one, wb);
        end
      end
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed_frame();
    test_abort();
    test_overlong();
    test_reset_midframe();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
